// File: rtl/wt_mult_sched.sv
`default_nettype none
// ============================================================================
// Module   : wt_mult_sched (with helper wt_rsp_fifo)
// Purpose  : Shares one pipelined signed multiplier between two requesters.
//            Round-robin arbitration with credit gating, owner-tag pipeline
//            matching the fixed multiplier latency, per-requester response
//            FIFOs (first-word fall-through).
// Revision : 1.0 - initial release
// ============================================================================

module wt_rsp_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic          o_valid,
    output logic [DW-1:0] o_data
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam logic [c_AW-1:0] c_LAST = c_AW'(DEPTH - 1);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    logic [DW-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0] r_wr;
    logic [c_AW-1:0] r_rd;
    logic [c_CW-1:0] r_cnt;
    logic            w_pop;
    logic            w_full;

    assign o_valid = (r_cnt != '0);
    assign w_full  = (r_cnt == c_FULL);
    assign w_pop   = i_pop && o_valid;
    // Head word is forced to zero while empty so stale storage never leaks out.
    assign o_data  = o_valid ? r_mem[r_rd] : '0;

    // Storage write; entries need no reset because reads are gated by r_cnt.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop together keeps r_cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) begin
                r_wr <= (r_wr == c_LAST) ? '0 : r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= (r_rd == c_LAST) ? '0 : r_rd + 1'b1;
            end
            case ({i_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Credits make overflow unreachable; a push into a full FIFO is a bug.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(i_push && w_full));

endmodule

module wt_mult_sched #(
    parameter int W      = 32,
    parameter int LAT    = 3,
    parameter int FIFO_D = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [W-1:0]   req0_x,
    input  logic [W-1:0]   req0_y,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [W-1:0]   req1_x,
    input  logic [W-1:0]   req1_y,
    output logic [W-1:0]   mul_x,
    output logic [W-1:0]   mul_y,
    output logic           mul_valid,
    input  logic [2*W-1:0] mul_p,
    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic [2*W-1:0] rsp0_p,
    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [2*W-1:0] rsp1_p
);
    localparam int c_CW = $clog2(FIFO_D + 1);
    localparam logic [c_CW-1:0] c_CRED_MAX = c_CW'(FIFO_D);

    // Round-robin pointer: which requester wins when both are eligible.
    typedef enum logic [0:0] {
        PTR_R0 = 1'b0,
        PTR_R1 = 1'b1
    } ptr_t;

    ptr_t            r_ptr;
    ptr_t            w_ptr_nxt;
    logic [c_CW-1:0] r_cred0;
    logic [c_CW-1:0] r_cred1;
    logic            w_elig0;
    logic            w_elig1;
    logic            w_grant0;
    logic            w_grant1;
    logic [W-1:0]    r_mul_x;
    logic [W-1:0]    r_mul_y;
    logic            r_mul_valid;
    logic            r_mul_own;      // 0 = requester 0, 1 = requester 1
    logic [LAT-1:0]  r_tag_v;
    logic [LAT-1:0]  r_tag_own;
    logic            w_push0;
    logic            w_push1;
    logic            w_pop0;
    logic            w_pop1;

    // A requester may only issue while it has a free response slot reserved.
    assign w_elig0 = req0_valid && (r_cred0 < c_CRED_MAX);
    assign w_elig1 = req1_valid && (r_cred1 < c_CRED_MAX);

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    assign mul_x     = r_mul_x;
    assign mul_y     = r_mul_y;
    assign mul_valid = r_mul_valid;

    // The tag leaving the last stage lines up with the product on mul_p.
    assign w_push0 = r_tag_v[LAT-1] && !r_tag_own[LAT-1];
    assign w_push1 = r_tag_v[LAT-1] &&  r_tag_own[LAT-1];
    assign w_pop0  = rsp0_valid && rsp0_ready;
    assign w_pop1  = rsp1_valid && rsp1_ready;

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= PTR_R0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // Grant selection; the pointer flips to the loser only when a grant occurs.
    always_comb begin
        w_grant0  = 1'b0;
        w_grant1  = 1'b0;
        w_ptr_nxt = r_ptr;
        if (w_elig0 && (!w_elig1 || (r_ptr == PTR_R0))) begin
            w_grant0  = 1'b1;
            w_ptr_nxt = PTR_R1;
        end else if (w_elig1) begin
            w_grant1  = 1'b1;
            w_ptr_nxt = PTR_R0;
        end
    end

    // Operand/issue registers; operands hold their last value when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mul_x     <= '0;
            r_mul_y     <= '0;
            r_mul_valid <= 1'b0;
            r_mul_own   <= 1'b0;
        end else begin
            r_mul_valid <= w_grant0 || w_grant1;
            if (w_grant0) begin
                r_mul_x   <= req0_x;
                r_mul_y   <= req0_y;
                r_mul_own <= 1'b0;
            end else if (w_grant1) begin
                r_mul_x   <= req1_x;
                r_mul_y   <= req1_y;
                r_mul_own <= 1'b1;
            end
        end
    end

    // Owner-tag shift register tracking each issue through the multiplier.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_v   <= '0;
            r_tag_own <= '0;
        end else begin
            r_tag_v[0]   <= r_mul_valid;
            r_tag_own[0] <= r_mul_own;
            for (int i = 1; i < LAT; i++) begin
                r_tag_v[i]   <= r_tag_v[i-1];
                r_tag_own[i] <= r_tag_own[i-1];
            end
        end
    end

    // Credit counters: +1 on accept, -1 on response handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cred0 <= '0;
            r_cred1 <= '0;
        end else begin
            case ({w_grant0, w_pop0})
                2'b10:   r_cred0 <= r_cred0 + 1'b1;
                2'b01:   r_cred0 <= r_cred0 - 1'b1;
                default: r_cred0 <= r_cred0;
            endcase
            case ({w_grant1, w_pop1})
                2'b10:   r_cred1 <= r_cred1 + 1'b1;
                2'b01:   r_cred1 <= r_cred1 - 1'b1;
                default: r_cred1 <= r_cred1;
            endcase
        end
    end

    wt_rsp_fifo #(
        .DW    (2 * W),
        .DEPTH (FIFO_D)
    ) u_rsp0 (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push0),
        .i_data  (mul_p),
        .i_pop   (rsp0_ready),
        .o_valid (rsp0_valid),
        .o_data  (rsp0_p)
    );

    wt_rsp_fifo #(
        .DW    (2 * W),
        .DEPTH (FIFO_D)
    ) u_rsp1 (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push1),
        .i_data  (mul_p),
        .i_pop   (rsp1_ready),
        .o_valid (rsp1_valid),
        .o_data  (rsp1_p)
    );

endmodule
`default_nettype wire

// File: tb/tb_wt_mult_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_wt_mult_sched
// Purpose  : Self-checking bench for wt_mult_sched with a behavioural
//            multiplier and a queue-based reference of the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wt_mult_sched;
    localparam int W      = 32;
    localparam int LAT    = 3;
    localparam int FIFO_D = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req0_valid = 1'b0, req1_valid = 1'b0;
    logic           req0_ready, req1_ready;
    logic [W-1:0]   req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
    logic [W-1:0]   mul_x, mul_y;
    logic           mul_valid;
    logic [2*W-1:0] mul_p;
    logic           rsp0_valid, rsp1_valid;
    logic           rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [2*W-1:0] rsp0_p, rsp1_p;

    int total = 0;
    int bad   = 0;

    wt_mult_sched #(.W(W), .LAT(LAT), .FIFO_D(FIFO_D)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
        .mul_x(mul_x), .mul_y(mul_y), .mul_valid(mul_valid), .mul_p(mul_p),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_p(rsp0_p),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_p(rsp1_p)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mulref(input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        return sx * sy;
    endfunction

    // Behavioural multiplier: pure LAT-stage pipeline, never reset.
    logic [2*W-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= mulref(mul_x, mul_y);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_p = pipe[LAT-1];

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Reference: per-requester queue of (cycle when visible, product).
    typedef struct {
        int          t;
        logic [63:0] p;
    } ent_t;
    ent_t mq [2][$];
    int   cred [2];
    int   ptr = 0;
    int   cyc = 0;

    task automatic model_cmp();
        logic        v [2];
        logic        e [2];
        logic        g [2];
        logic        ev [2];
        logic        rdy [2];
        logic        rr [2];
        logic        dv [2];
        logic [63:0] dp [2];
        logic [31:0] xx [2];
        logic [31:0] yy [2];
        ent_t        ent;
        if (rst) begin
            mq[0].delete(); mq[1].delete();
            cred[0] = 0; cred[1] = 0; ptr = 0;
            cyc++;
            return;
        end
        v[0] = req0_valid;  v[1] = req1_valid;
        rdy[0] = req0_ready; rdy[1] = req1_ready;
        rr[0] = rsp0_ready;  rr[1] = rsp1_ready;
        dv[0] = rsp0_valid;  dv[1] = rsp1_valid;
        dp[0] = rsp0_p;      dp[1] = rsp1_p;
        xx[0] = req0_x; yy[0] = req0_y; xx[1] = req1_x; yy[1] = req1_y;
        for (int i = 0; i < 2; i++) e[i] = v[i] && (cred[i] < FIFO_D);
        g[0] = e[0] && (!e[1] || ptr == 0);
        g[1] = e[1] && !g[0];
        for (int i = 0; i < 2; i++) begin
            ev[i] = (mq[i].size() > 0) && (mq[i][0].t <= cyc);
            chk($sformatf("model_ready%0d", i), rdy[i], g[i]);
            chk($sformatf("model_rsp%0d_valid", i), dv[i], ev[i]);
            if (ev[i]) chk($sformatf("model_rsp%0d_p", i), dp[i], mq[i][0].p);
            if (g[i]) begin
                ent.t = cyc + LAT + 2;
                ent.p = mulref(xx[i], yy[i]);
                mq[i].push_back(ent);
                cred[i]++;
                ptr = 1 - i;
            end
            if (ev[i] && rr[i]) begin
                void'(mq[i].pop_front());
                cred[i]--;
            end
        end
        cyc++;
    endtask

    task automatic settle(); @(negedge clk); model_cmp(); endtask
    task automatic adv();    @(posedge clk); #1;          endtask
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin settle(); adv(); end
    endtask
    task automatic do_reset();
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        run(1);
        rst = 1'b0;
    endtask

    // One isolated req0 op: checks issue registers, latency and product.
    task automatic single(input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] exp, input string nm);
        req0_x = x; req0_y = y; req0_valid = 1'b1; rsp0_ready = 1'b1;
        settle();
        chk({nm, "_accept"}, req0_ready, 1'b1);
        adv();
        req0_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            settle();
            if (k == 1) begin
                chk({nm, "_mul_valid"}, mul_valid, 1'b1);
                chk({nm, "_mul_x"}, mul_x, x);
                chk({nm, "_mul_y"}, mul_y, y);
            end
            if (k == 2) begin
                chk({nm, "_mul_idle"}, mul_valid, 1'b0);
                chk({nm, "_mul_x_hold"}, mul_x, x);
            end
            if (k == 4) chk({nm, "_not_early"}, rsp0_valid, 1'b0);
            if (k == 5) begin
                chk({nm, "_rsp_valid"}, rsp0_valid, 1'b1);
                chk({nm, "_rsp_p"}, rsp0_p, exp);
                chk({nm, "_rsp1_quiet"}, rsp1_valid, 1'b0);
            end
            adv();
        end
    endtask

    initial begin
        logic a0, a1;
        int   n, acc, pops;

        run(2);
        rst = 1'b0;

        // Reset state
        settle();
        chk("rst_mul_valid", mul_valid, 1'b0);
        chk("rst_mul_x", mul_x, 32'h0);
        chk("rst_mul_y", mul_y, 32'h0);
        chk("rst_rsp0_valid", rsp0_valid, 1'b0);
        chk("rst_rsp1_valid", rsp1_valid, 1'b0);
        chk("rst_rsp0_p", rsp0_p, 64'h0);
        chk("rst_rsp1_p", rsp1_p, 64'h0);
        adv();

        // Directed single ops with hand-computed products
        single(32'hFFFFFFFF, 32'h00000002, 64'hFFFFFFFFFFFFFFFE, "neg1x2");
        single(32'h80000000, 32'h80000000, 64'h4000000000000000, "minxmin");
        single(32'h80000000, 32'h7FFFFFFF, 64'hC000000080000000, "minxmax");
        single(32'h00000000, 32'h12345678, 64'h0, "zero");

        // Both requesters continuously valid: strict alternation from req0
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_x = $urandom; req0_y = $urandom; req1_x = $urandom; req1_y = $urandom;
        for (int i = 0; i < 16; i++) begin
            settle();
            chk("alt_ready0", req0_ready, (i % 2 == 0));
            chk("alt_ready1", req1_ready, (i % 2 == 1));
            a0 = req0_ready; a1 = req1_ready;
            adv();
            if (a0) begin req0_x = $urandom; req0_y = $urandom; end
            if (a1) begin req1_x = $urandom; req1_y = $urandom; end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        run(8);

        // Credit exhaustion on requester 1
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_x = 32'h00001234; req1_y = 32'hFFFFFFFD;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            settle();
            if (req1_ready) n++;
            adv();
        end
        chk("cred_accepts1", n, 4);
        req0_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("cred_req0_ok", req0_ready, 1'b1);
            chk("cred_req1_blocked", req1_ready, 1'b0);
            adv();
            req0_x = $urandom; req0_y = $urandom;
        end
        req0_valid = 1'b0;
        rsp1_ready = 1'b1;
        settle();
        chk("cred_req1_still_blocked", req1_ready, 1'b0);
        adv();
        settle();
        chk("cred_req1_resume", req1_ready, 1'b1);
        adv();
        run(12);
        req1_valid = 1'b0;
        run(10);

        // Response backpressure toggling with refill
        do_reset();
        rsp0_ready = 1'b0; rsp1_ready = 1'b1; req0_valid = 1'b1;
        req0_x = $urandom; req0_y = $urandom;
        acc = 0; pops = 0;
        for (int i = 0; i < 40; i++) begin
            settle();
            if (req0_ready) acc++;
            if (rsp0_valid && rsp0_ready) pops++;
            a0 = req0_ready;
            adv();
            if (a0) begin req0_x = $urandom; req0_y = $urandom; end
            if (i >= 8) rsp0_ready = (i < 30) ? ~rsp0_ready : 1'b1;
            if (i == 20) req0_valid = 1'b0;
        end
        chk("toggle_conservation", pops, acc);
        settle();
        chk("toggle_drained", rsp0_valid, 1'b0);
        adv();

        // Reset with 2 buffered (req0) and 3 in flight (req1)
        do_reset();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req0_valid = (i < 2);
            req1_valid = (i >= 5);
            req0_x = $urandom; req0_y = $urandom; req1_x = $urandom; req1_y = $urandom;
            settle();
            adv();
        end
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        settle();
        adv();
        rst = 1'b0;
        settle();
        chk("mid_rst_rsp0", rsp0_valid, 1'b0);
        chk("mid_rst_rsp1", rsp1_valid, 1'b0);
        chk("mid_rst_mul_valid", mul_valid, 1'b0);
        adv();
        for (int i = 0; i < 8; i++) begin
            settle();
            chk("stale_rsp0", rsp0_valid, 1'b0);
            chk("stale_rsp1", rsp1_valid, 1'b0);
            adv();
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        settle();
        chk("post_rst_grant0", req0_ready, 1'b1);
        chk("post_rst_grant1", req1_ready, 1'b0);
        adv();
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        run(10);

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            settle();
            a0 = req0_ready; a1 = req1_ready;
            adv();
            if (!req0_valid || a0) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_x = $urandom; req0_y = $urandom;
            end
            if (!req1_valid || a1) begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_x = $urandom; req1_y = $urandom;
            end
            rsp0_ready = ($urandom_range(0, 2) != 0);
            rsp1_ready = ($urandom_range(0, 2) != 0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        run(15);
        settle();
        chk("final_drain0", rsp0_valid, 1'b0);
        chk("final_drain1", rsp1_valid, 1'b0);
        adv();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
